// File: rtl/keypad_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_unit_pkg
//  Description : Shared keypad definitions: key codes ({row,col}), matrix
//                size, default operand length, datapath width and helpers
//                that translate a key code into a decimal digit.
//  Revision    : 1.0 - initial release
// ============================================================================
package keypad_unit_pkg;

   localparam int ISA_WIDTH         = 32;
   localparam int KEYPAD_ROWS       = 4;
   localparam int KEYPAD_COLS       = 4;
   localparam int DIGIT_MAX_DEFAULT = 8;

   typedef logic [3:0] key_code_t;

   // Key code = {row[1:0], col[1:0]}; layout 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
   localparam key_code_t KEY_1    = 4'd0;
   localparam key_code_t KEY_2    = 4'd1;
   localparam key_code_t KEY_3    = 4'd2;
   localparam key_code_t KEY_A    = 4'd3;
   localparam key_code_t KEY_4    = 4'd4;
   localparam key_code_t KEY_5    = 4'd5;
   localparam key_code_t KEY_6    = 4'd6;
   localparam key_code_t KEY_B    = 4'd7;
   localparam key_code_t KEY_7    = 4'd8;
   localparam key_code_t KEY_8    = 4'd9;
   localparam key_code_t KEY_9    = 4'd10;
   localparam key_code_t KEY_C    = 4'd11;
   localparam key_code_t KEY_STAR = 4'd12;
   localparam key_code_t KEY_0    = 4'd13;
   localparam key_code_t KEY_HASH = 4'd14;
   localparam key_code_t KEY_D    = 4'd15;

   function automatic logic key_is_digit(input key_code_t k);
      case (k)
         KEY_0, KEY_1, KEY_2, KEY_3, KEY_4,
         KEY_5, KEY_6, KEY_7, KEY_8, KEY_9: key_is_digit = 1'b1;
         default:                           key_is_digit = 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] key_digit(input key_code_t k);
      case (k)
         KEY_1:   key_digit = 4'd1;
         KEY_2:   key_digit = 4'd2;
         KEY_3:   key_digit = 4'd3;
         KEY_4:   key_digit = 4'd4;
         KEY_5:   key_digit = 4'd5;
         KEY_6:   key_digit = 4'd6;
         KEY_7:   key_digit = 4'd7;
         KEY_8:   key_digit = 4'd8;
         KEY_9:   key_digit = 4'd9;
         default: key_digit = 4'd0;
      endcase
   endfunction

endpackage : keypad_unit_pkg
`default_nettype wire

// File: rtl/keypad_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_unit_if
//  Description : Level handshake between the keypad unit and data_mem.
//                master = keypad unit (produces operand), slave = data_mem.
//  Ports       : keypad_read_enable   - data_mem requests an operand
//                keypad_read_complete - operand is valid and held
//                keypad_data          - binary operand
//  Revision    : 1.0 - initial release
// ============================================================================
interface keypad_unit_if
   import keypad_unit_pkg::*;
();
   logic                 keypad_read_enable;
   logic                 keypad_read_complete;
   logic [ISA_WIDTH-1:0] keypad_data;

   modport master (
      input  keypad_read_enable,
      output keypad_read_complete,
      output keypad_data
   );

   modport slave (
      output keypad_read_enable,
      input  keypad_read_complete,
      input  keypad_data
   );
endinterface : keypad_unit_if
`default_nettype wire

// File: rtl/keypad_unit_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scanner
//  Description : Synchronises the active-low rows, rotates a one-cold column
//                drive and debounces both press and release of single keys.
//  Ports       : clk, rst_n  - clock / async active-low reset
//                row_in      - raw rows (active-low, asynchronous)
//                col_out     - one-cold column drive
//                key_code    - {row,col} of the last debounced key
//                key_event   - one-cycle strobe per debounced press
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_scanner
   import keypad_unit_pkg::*;
#(
   parameter int SCAN_DIV     = 50000,
   parameter int DEBOUNCE_CNT = 200000
)(
   input  logic      clk,
   input  logic      rst_n,
   input  logic [3:0] row_in,
   output logic [3:0] col_out,
   output key_code_t key_code,
   output logic      key_event
);
   localparam int SD_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DB_W = $clog2(DEBOUNCE_CNT + 1);

   localparam logic [1:0] c_SCAN         = 2'd0;
   localparam logic [1:0] c_DEBOUNCE     = 2'd1;
   localparam logic [1:0] c_WAIT_RELEASE = 2'd2;

   logic [3:0]      r_row_meta, r_row_sync;
   logic [1:0]      r_state;
   logic [1:0]      r_col;
   logic [SD_W-1:0] r_div;
   logic [DB_W-1:0] r_db;
   logic [3:0]      r_pattern;
   key_code_t       r_key_code;
   logic            r_key_event;

   logic            w_slot_end, w_db_done, w_one_low;
   logic [1:0]      w_row_idx;

   assign w_slot_end = (r_div == SD_W'(SCAN_DIV - 1));
   assign w_db_done  = (r_db == DB_W'(DEBOUNCE_CNT - 1));

   // A key is only accepted when exactly one row is pulled low.
   always_comb begin
      w_one_low = 1'b1;
      w_row_idx = 2'd0;
      case (r_row_sync)
         4'b1110: w_row_idx = 2'd0;
         4'b1101: w_row_idx = 2'd1;
         4'b1011: w_row_idx = 2'd2;
         4'b0111: w_row_idx = 2'd3;
         default: w_one_low = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_row_meta  <= 4'hF;
         r_row_sync  <= 4'hF;
         r_state     <= c_SCAN;
         r_col       <= 2'd0;
         r_div       <= '0;
         r_db        <= '0;
         r_pattern   <= 4'hF;
         r_key_code  <= 4'd0;
         r_key_event <= 1'b0;
      end else begin
         r_row_meta  <= row_in;
         r_row_sync  <= r_row_meta;
         r_key_event <= 1'b0;
         case (r_state)
            c_SCAN: begin
               if (w_slot_end) begin
                  r_div <= '0;
                  if (w_one_low) begin
                     // Column stays frozen on the pressed key until release.
                     r_key_code <= {w_row_idx, r_col};
                     r_pattern  <= r_row_sync;
                     r_db       <= '0;
                     r_state    <= c_DEBOUNCE;
                  end else begin
                     r_col <= r_col + 2'd1;
                  end
               end else begin
                  r_div <= r_div + SD_W'(1);
               end
            end
            c_DEBOUNCE: begin
               if (r_row_sync == r_pattern) begin
                  if (w_db_done) begin
                     r_key_event <= 1'b1;
                     r_db        <= '0;
                     r_state     <= c_WAIT_RELEASE;
                  end else begin
                     r_db <= r_db + DB_W'(1);
                  end
               end else begin
                  r_db    <= '0;
                  r_state <= c_SCAN;
               end
            end
            c_WAIT_RELEASE: begin
               if (r_row_sync == 4'hF) begin
                  if (w_db_done) begin
                     r_db    <= '0;
                     r_state <= c_SCAN;
                  end else begin
                     r_db <= r_db + DB_W'(1);
                  end
               end else begin
                  r_db <= '0;
               end
            end
            default: r_state <= c_SCAN;
         endcase
      end
   end

   assign col_out   = ~(4'b0001 << r_col);
   assign key_code  = r_key_code;
   assign key_event = r_key_event;

endmodule : keypad_scanner
`default_nettype wire

// File: rtl/keypad_unit.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_unit
//  Description : Matrix keypad front end. Builds decimal operands for
//                keypad-read instructions, hands them to data_mem via a level
//                handshake, and raises pause/resume/UART-start pulses.
//  Ports       : clk, rst_n    - clock / async active-low reset
//                row_in        - keypad rows (active-low, async)
//                col_out       - keypad column drive (one-cold)
//                kbus          - operand handshake (enable/complete/data)
//                digit_count   - digits entered so far
//                cpu_pause, cpu_resume, uart_start - one-cycle pulses
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_unit
   import keypad_unit_pkg::*;
#(
   parameter int SCAN_DIV     = 50000,
   parameter int DEBOUNCE_CNT = 200000,
   parameter int DIGIT_MAX    = DIGIT_MAX_DEFAULT
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic [3:0]    row_in,
   output logic [3:0]    col_out,
   keypad_unit_if.master kbus,
   output logic [3:0]    digit_count,
   output logic          cpu_pause,
   output logic          cpu_resume,
   output logic          uart_start
);
   localparam logic [ISA_WIDTH-1:0] c_TEN       = ISA_WIDTH'(10);
   localparam logic [3:0]           c_DIGIT_MAX = 4'(DIGIT_MAX);

   key_code_t            w_key_code;
   logic                 w_key_event;
   logic                 w_enable;

   logic [ISA_WIDTH-1:0] r_data;
   logic [3:0]           r_count;
   logic                 r_complete;
   logic                 r_paused;
   logic                 r_pause, r_resume, r_uart;

   keypad_scanner #(
      .SCAN_DIV     (SCAN_DIV),
      .DEBOUNCE_CNT (DEBOUNCE_CNT)
   ) u_scanner (
      .clk       (clk),
      .rst_n     (rst_n),
      .row_in    (row_in),
      .col_out   (col_out),
      .key_code  (w_key_code),
      .key_event (w_key_event)
   );

   assign w_enable = kbus.keypad_read_enable;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data     <= '0;
         r_count    <= 4'd0;
         r_complete <= 1'b0;
         r_paused   <= 1'b0;
         r_pause    <= 1'b0;
         r_resume   <= 1'b0;
         r_uart     <= 1'b0;
      end else begin
         r_pause  <= 1'b0;
         r_resume <= 1'b0;
         r_uart   <= 1'b0;

         // data_mem has consumed the operand: release it in one step.
         // Every operand key is a no-op in this cycle anyway (complete=1).
         if (!w_enable && r_complete) begin
            r_complete <= 1'b0;
            r_data     <= '0;
            r_count    <= 4'd0;
         end else if (w_key_event) begin
            if (key_is_digit(w_key_code)) begin
               if (w_enable && !r_complete && (r_count < c_DIGIT_MAX)) begin
                  r_data  <= r_data * c_TEN + ISA_WIDTH'(key_digit(w_key_code));
                  r_count <= r_count + 4'd1;
               end
            end else begin
               case (w_key_code)
                  KEY_C: begin
                     if (!r_complete && (r_count != 4'd0)) begin
                        r_data  <= r_data / c_TEN;
                        r_count <= r_count - 4'd1;
                     end
                  end
                  KEY_D: begin
                     if (!r_complete) begin
                        r_data  <= '0;
                        r_count <= 4'd0;
                     end
                  end
                  KEY_HASH: begin
                     if (w_enable) r_complete <= 1'b1;
                  end
                  default: ;
               endcase
            end
         end

         // Interrupt keys act independently of the operand handshake.
         if (w_key_event) begin
            if (w_key_code == KEY_A) begin
               r_paused <= ~r_paused;
               if (r_paused) r_resume <= 1'b1;
               else          r_pause  <= 1'b1;
            end else if ((w_key_code == KEY_B) && !r_paused) begin
               r_uart <= 1'b1;
            end
         end
      end
   end

   assign kbus.keypad_read_complete = r_complete;
   assign kbus.keypad_data          = r_data;
   assign digit_count               = r_count;
   assign cpu_pause                 = r_pause;
   assign cpu_resume                = r_resume;
   assign uart_start                = r_uart;

endmodule : keypad_unit
`default_nettype wire

// File: tb/tb_keypad_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_unit
//  Description : Testbench for keypad_unit. A matrix model turns pressed keys
//                into row levels; a behavioural keypad model predicts every
//                visible output change and a monitor compares them in order.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_unit;
   localparam int SD = 4;
   localparam int DB = 8;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  cnt;
      logic        cmp;
      logic        pause;
      logic        resume;
      logic        uart;
   } obs_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] row_in;
   logic [3:0] col_out;
   logic [3:0] digit_count;
   logic       cpu_pause, cpu_resume, uart_start;
   logic [15:0] pressed;

   keypad_unit_if kbus();

   keypad_unit #(
      .SCAN_DIV     (SD),
      .DEBOUNCE_CNT (DB),
      .DIGIT_MAX    (8)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .row_in      (row_in),
      .col_out     (col_out),
      .kbus        (kbus),
      .digit_count (digit_count),
      .cpu_pause   (cpu_pause),
      .cpu_resume  (cpu_resume),
      .uart_start  (uart_start)
   );

   always #5 clk = ~clk;

   // Key index k sits at row k/4, column k%4; a row reads low when one of its
   // pressed keys lies in the column currently driven low.
   always_comb begin
      row_in = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
   end

   int    n_vec = 0;
   int    n_bad = 0;
   obs_t  exp_q[$];
   bit    mon_en = 1'b0;
   obs_t  prev, cur, expv;

   // Behavioural keypad model
   string  keymap = "123A456B789C*0#D";
   longint m_data = 0;
   int     m_cnt = 0;
   bit     m_cmp = 0, m_paused = 0, m_en = 0;

   always @(negedge clk) begin
      cur.data   = kbus.keypad_data;
      cur.cnt    = digit_count;
      cur.cmp    = kbus.keypad_read_complete;
      cur.pause  = cpu_pause;
      cur.resume = cpu_resume;
      cur.uart   = uart_start;
      if (mon_en && rst_n) begin
         if (cur.data != prev.data || cur.cnt != prev.cnt || cur.cmp != prev.cmp ||
             cur.pause || cur.resume || cur.uart) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_output: got data=%0d cnt=%0d cmp=%0b p/r/u=%0b%0b%0b, none required",
                        cur.data, cur.cnt, cur.cmp, cur.pause, cur.resume, cur.uart);
            end else begin
               expv = exp_q.pop_front();
               if (cur !== expv) begin
                  n_bad++;
                  $display("FAIL output_seq: got data=%0d cnt=%0d cmp=%0b p/r/u=%0b%0b%0b, required data=%0d cnt=%0d cmp=%0b p/r/u=%0b%0b%0b",
                           cur.data, cur.cnt, cur.cmp, cur.pause, cur.resume, cur.uart,
                           expv.data, expv.cnt, expv.cmp, expv.pause, expv.resume, expv.uart);
               end
            end
         end
      end
      prev = cur;
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
      n_vec++;
      if (got !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h", nm, got, req);
      end
   endtask

   task automatic push_state(input bit p, input bit r, input bit u);
      obs_t e;
      e.data = 32'(m_data); e.cnt = 4'(m_cnt); e.cmp = m_cmp;
      e.pause = p; e.resume = r; e.uart = u;
      exp_q.push_back(e);
   endtask

   // Predicts the effect of one debounced press of key k.
   task automatic model_key(input int k);
      byte ch;
      ch = keymap[k];
      if (ch >= "0" && ch <= "9") begin
         if (m_en && !m_cmp && m_cnt < 8) begin
            m_data = m_data * 10 + longint'(ch - "0");
            m_cnt++;
            push_state(0, 0, 0);
         end
      end else if (ch == "C") begin
         if (!m_cmp && m_cnt > 0) begin
            m_data = m_data / 10; m_cnt--; push_state(0, 0, 0);
         end
      end else if (ch == "D") begin
         if (!m_cmp && m_cnt > 0) begin
            m_data = 0; m_cnt = 0; push_state(0, 0, 0);
         end
      end else if (ch == "#") begin
         if (m_en && !m_cmp) begin
            m_cmp = 1; push_state(0, 0, 0);
         end
      end else if (ch == "A") begin
         if (m_paused) push_state(0, 1, 0);
         else          push_state(1, 0, 0);
         m_paused = !m_paused;
      end else if (ch == "B") begin
         if (!m_paused) push_state(0, 0, 1);
      end
   endtask

   task automatic set_enable(input bit v);
      if (!v && m_cmp) begin
         m_cmp = 0; m_data = 0; m_cnt = 0; push_state(0, 0, 0);
      end
      m_en = v;
      kbus.keypad_read_enable = v;
      repeat (4) @(negedge clk);
   endtask

   task automatic press(input int k, input int hold, input int rel);
      model_key(k);
      pressed[k] = 1'b1;
      repeat (hold) @(negedge clk);
      pressed[k] = 1'b0;
      repeat (rel) @(negedge clk);
   endtask

   task automatic press_seq(input string s);
      for (int i = 0; i < s.len(); i++)
         for (int k = 0; k < 16; k++)
            if (keymap[k] == s[i]) press(k, 40, 40);
   endtask

   initial begin
      bit seen;
      pressed = '0;
      kbus.keypad_read_enable = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_col_out", 32'(col_out), 32'he);
      chk("rst_data", kbus.keypad_data, 32'd0);
      chk("rst_count", 32'(digit_count), 32'd0);
      chk("rst_complete", 32'(kbus.keypad_read_complete), 32'd0);
      chk("rst_pulses", 32'({cpu_pause, cpu_resume, uart_start}), 32'd0);
      rst_n  = 1'b1;
      mon_en = 1'b1;

      // Operand 42, enter, then release of the handshake.
      set_enable(1);
      press_seq("42#");
      chk("hold_data", kbus.keypad_data, 32'd42);
      set_enable(0);
      chk("clear_complete", 32'(kbus.keypad_read_complete), 32'd0);

      // Short bounce must not register.
      set_enable(1);
      pressed[5] = 1'b1;
      repeat (3) @(negedge clk);
      pressed[5] = 1'b0;
      repeat (40) @(negedge clk);

      // Nine digits saturate at eight; then backspace and clear.
      press_seq("123456789");
      chk("max_digits", 32'(digit_count), 32'd8);
      press_seq("CD");

      // Two rows low in one column are ignored.
      pressed[1] = 1'b1; pressed[5] = 1'b1;
      repeat (60) @(negedge clk);
      pressed = '0;
      repeat (40) @(negedge clk);

      // Long hold yields a single digit.
      press(8, 500, 40);

      // Pause / UART gating / resume.
      press_seq("ABAB");

      // Asynchronous reset while a press of '6' (column 2) is debouncing.
      pressed[6] = 1'b1;
      seen = 0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (col_out == 4'b1011) seen = 1;
      end
      chk("col2_reached", 32'(seen), 32'd1);
      repeat (7) @(negedge clk);
      chk("queue_drained_pre_reset", 32'(exp_q.size()), 32'd0);
      mon_en = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_col_out", 32'(col_out), 32'he);
      chk("arst_data", kbus.keypad_data, 32'd0);
      chk("arst_count", 32'(digit_count), 32'd0);
      chk("arst_outputs", 32'({kbus.keypad_read_complete, cpu_pause, cpu_resume, uart_start}), 32'd0);
      pressed = '0;
      m_data = 0; m_cnt = 0; m_cmp = 0; m_paused = 0;
      repeat (3) @(negedge clk);
      rst_n  = 1'b1;
      mon_en = 1'b1;

      // Randomised keys and enable toggling.
      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 9) < 2)
            set_enable(1'($urandom_range(0, 1)));
         else
            press(int'($urandom_range(0, 15)), 35 + int'($urandom_range(0, 15)),
                  30 + int'($urandom_range(0, 10)));
      end

      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
      chk("queue_drained_end", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule : tb_keypad_unit
`default_nettype wire
